// File: rtl/nn_pkg.sv
// Shared sizing, FSM state encoding and result record for the classifier readout path.
// Imported by the argmax stage and its top-1/top-2 tracker.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  top2_idx;
    logic [DATA_W-1:0] top2_val;
    logic [DATA_W-1:0] margin;
    logic              low_conf;
  } result_t;

endpackage

// File: rtl/argmax_top2_tracker.sv
// Serial top-1/top-2 tracker: one candidate per enabled cycle, updated pair visible the next cycle.
// Strict compares keep the lower index on ties; clear re-arms it for a new vector.
module argmax_top2_tracker
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] val,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] top1_val,
  output logic [IDX_W-1:0]  top1_idx,
  output logic [DATA_W-1:0] top2_val,
  output logic [IDX_W-1:0]  top2_idx
);

  logic top2_empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      top1_val   <= '0;
      top1_idx   <= '0;
      top2_val   <= '0;
      top2_idx   <= '0;
      top2_empty <= 1'b1;
    end else if (en) begin
      // The cleared top-1 is only provisional: the first element seeds it
      // instead of competing, so an all-zero vector still yields top2_idx = 1.
      if (first || (val > top1_val)) begin
        top1_val <= val;
        top1_idx <= idx;
        if (!first) begin
          top2_val   <= top1_val;
          top2_idx   <= top1_idx;
          top2_empty <= 1'b0;
        end
      end else if (top2_empty || (val > top2_val)) begin
        top2_val   <= val;
        top2_idx   <= idx;
        top2_empty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Captures a softmax vector, scans one class per cycle; result valid NUM_CLASSES+1 cycles after capture.
// Result slot holds under res_ready low; frames arriving while busy are dropped and counted (saturating).
module argmax_classifier
  import nn_pkg::*;
#(
  parameter logic [DATA_W-1:0] CONF_THRESH = 16'h4000,
  parameter logic [DATA_W-1:0] MARGIN_MIN  = 16'h0800,
  parameter int                DROP_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] prob_in,
  input  logic                          in_valid,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [IDX_W-1:0]              class_idx,
  output logic [DATA_W-1:0]             top1_val,
  output logic [IDX_W-1:0]              top2_idx,
  output logic [DATA_W-1:0]             top2_val,
  output logic [DATA_W-1:0]             margin,
  output logic                          low_conf,
  output logic [DROP_W-1:0]             drop_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state;
  logic [DATA_W-1:0] vec [NUM_CLASSES];
  logic [IDX_W-1:0]  idx;
  result_t           res_q;
  result_t           res_d;
  logic [DATA_W-1:0] t1_val;
  logic [DATA_W-1:0] t2_val;
  logic [IDX_W-1:0]  t1_idx;
  logic [IDX_W-1:0]  t2_idx;
  logic              slot_free;
  logic              accept;

  assign accept    = (state == IDLE) && in_valid;
  assign slot_free = !res_valid || res_ready;
  assign busy      = (state != IDLE);

  argmax_top2_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (state == SCAN),
    .first    (idx == '0),
    .val      (vec[idx]),
    .idx      (idx),
    .top1_val (t1_val),
    .top1_idx (t1_idx),
    .top2_val (t2_val),
    .top2_idx (t2_idx)
  );

  always_comb begin
    res_d          = '0;
    res_d.idx      = t1_idx;
    res_d.val      = t1_val;
    res_d.top2_idx = t2_idx;
    res_d.top2_val = t2_val;
    res_d.margin   = t1_val - t2_val;
    res_d.low_conf = (t1_val < CONF_THRESH) || (res_d.margin < MARGIN_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      res_q      <= '0;
      res_valid  <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) vec[i] <= '0;
    end else begin
      if (in_valid && (state != IDLE) && (drop_count != {DROP_W{1'b1}}))
        drop_count <= drop_count + 1'b1;
      // A load in DONE below overrides this clear when both happen together.
      if (res_valid && res_ready)
        res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_CLASSES; i++) vec[i] <= prob_in[i*DATA_W +: DATA_W];
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) state <= DONE;
          else                 idx   <= idx + 1'b1;
        end
        DONE: begin
          if (slot_free) begin
            res_q     <= res_d;
            res_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign class_idx = res_q.idx;
  assign top1_val  = res_q.val;
  assign top2_idx  = res_q.top2_idx;
  assign top2_val  = res_q.top2_val;
  assign margin    = res_q.margin;
  assign low_conf  = res_q.low_conf;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboarded bench for argmax_classifier: a default instance plus a DROP_W=2 instance on shared stimulus.
module tb_argmax_classifier;
  import nn_pkg::*;

  localparam int VW = NUM_CLASSES * DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          res_ready;
  logic [VW-1:0] prob_in;

  logic              busy_a, res_valid_a, low_conf_a;
  logic [IDX_W-1:0]  class_idx_a, top2_idx_a;
  logic [DATA_W-1:0] top1_val_a, top2_val_a, margin_a;
  logic [7:0]        drop_count_a;

  logic              busy_s, res_valid_s, low_conf_s;
  logic [IDX_W-1:0]  class_idx_s, top2_idx_s;
  logic [DATA_W-1:0] top1_val_s, top2_val_s, margin_s;
  logic [1:0]        drop_count_s;

  int total = 0;
  int bad   = 0;
  int exp_drops = 0;
  int n;
  logic [VW-1:0] v;
  result_t ea, eb;
  result_t q_a[$];
  result_t q_s[$];

  argmax_classifier dut_a (
    .clk(clk), .rst(rst), .prob_in(prob_in), .in_valid(in_valid), .busy(busy_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .class_idx(class_idx_a),
    .top1_val(top1_val_a), .top2_idx(top2_idx_a), .top2_val(top2_val_a),
    .margin(margin_a), .low_conf(low_conf_a), .drop_count(drop_count_a)
  );

  argmax_classifier #(.DROP_W(2)) dut_s (
    .clk(clk), .rst(rst), .prob_in(prob_in), .in_valid(in_valid), .busy(busy_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .class_idx(class_idx_s),
    .top1_val(top1_val_s), .top2_idx(top2_idx_s), .top2_val(top2_val_s),
    .margin(margin_s), .low_conf(low_conf_s), .drop_count(drop_count_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before test end, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Reference: top-1 is the first maximum; top-2 is the first maximum among the remaining classes.
  function automatic result_t model(input logic [VW-1:0] p);
    result_t r;
    logic [DATA_W-1:0] x [NUM_CLASSES];
    int b1, b2;
    for (int i = 0; i < NUM_CLASSES; i++) x[i] = p[i*DATA_W +: DATA_W];
    b1 = 0;
    for (int i = 1; i < NUM_CLASSES; i++) if (x[i] > x[b1]) b1 = i;
    b2 = (b1 == 0) ? 1 : 0;
    for (int i = 0; i < NUM_CLASSES; i++) if (i != b1 && x[i] > x[b2]) b2 = i;
    r.idx      = IDX_W'(b1);
    r.val      = x[b1];
    r.top2_idx = IDX_W'(b2);
    r.top2_val = x[b2];
    r.margin   = x[b1] - x[b2];
    r.low_conf = (x[b1] < 16'h4000) || (r.margin < 16'h0800);
    return r;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [DATA_W-1:0] base);
    logic [VW-1:0] p;
    for (int i = 0; i < NUM_CLASSES; i++) p[i*DATA_W +: DATA_W] = base;
    return p;
  endfunction

  function automatic logic [VW-1:0] rand_frame();
    logic [VW-1:0] p;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (mode == 0)      p[i*DATA_W +: DATA_W] = 16'($urandom);
      else if (mode == 1) p[i*DATA_W +: DATA_W] = 16'($urandom_range(0, 4) * 32'h0800);
      else                p[i*DATA_W +: DATA_W] = 16'($urandom_range(0, 32'h0900));
    end
    return p;
  endfunction

  task automatic chk_res(input string tag, input logic [IDX_W-1:0] ci, input logic [DATA_W-1:0] t1,
                         input logic [IDX_W-1:0] t2i, input logic [DATA_W-1:0] t2,
                         input logic [DATA_W-1:0] m, input logic lc, input result_t e);
    chk({tag, "_class_idx"}, 32'(ci), 32'(e.idx));
    chk({tag, "_top1_val"},  32'(t1), 32'(e.val));
    chk({tag, "_top2_idx"},  32'(t2i), 32'(e.top2_idx));
    chk({tag, "_top2_val"},  32'(t2), 32'(e.top2_val));
    chk({tag, "_margin"},    32'(m), 32'(e.margin));
    chk({tag, "_low_conf"},  32'(lc), 32'(e.low_conf));
  endtask

  always @(negedge clk) begin
    if (res_valid_a === 1'b1 && res_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_a: got class %0d, required no result", class_idx_a);
      end else begin
        chk_res("a", class_idx_a, top1_val_a, top2_idx_a, top2_val_a, margin_a, low_conf_a, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (res_valid_s === 1'b1 && res_ready === 1'b1) begin
      if (q_s.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_s: got class %0d, required no result", class_idx_s);
      end else begin
        chk_res("s", class_idx_s, top1_val_s, top2_idx_s, top2_val_s, margin_s, low_conf_s, q_s.pop_front());
      end
    end
  end

  // Drives in_valid so it is sampled 'gap' edges after the previously sampled one.
  task automatic send(input logic [VW-1:0] p, input int gap, input bit push);
    result_t e;
    repeat (gap - 1) @(posedge clk);
    #1;
    prob_in  = p;
    in_valid = 1'b1;
    if (push) begin
      e = model(p);
      q_a.push_back(e);
      q_s.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int k;
    k = 0;
    while ((q_a.size() != 0 || q_s.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      if (rnd) res_ready = 1'($urandom_range(0, 1));
      k++;
    end
    total++;
    if (q_a.size() != 0 || q_s.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d results outstanding after %0d cycles, required 0",
               q_a.size(), q_s.size(), budget);
      q_a.delete();
      q_s.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;
  endtask

  task automatic chk_drops(input string tag);
    chk({tag, "_drop_a"}, 32'(drop_count_a), 32'(exp_drops));
    chk({tag, "_drop_s"}, 32'(drop_count_s), 32'((exp_drops > 3) ? 3 : exp_drops));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; prob_in = '0;
    do_reset();
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid_a), 0);
    chk("rst_busy",      32'(busy_a), 0);
    chk("rst_class_idx", 32'(class_idx_a), 0);
    chk("rst_top1",      32'(top1_val_a), 0);
    chk("rst_top2_idx",  32'(top2_idx_a), 0);
    chk("rst_margin",    32'(margin_a), 0);
    chk("rst_low_conf",  32'(low_conf_a), 0);
    chk("rst_res_valid_s", 32'(res_valid_s), 0);
    chk_drops("rst");

    // One-hot frame with latency measurement
    res_ready = 1'b1;
    v = fill(16'h0010);
    v[7*DATA_W +: DATA_W] = 16'h7F00;
    send(v, 1, 1);
    n = 0;
    @(negedge clk);
    while (res_valid_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 11);
    wait_drain(50, 0);

    // Tie between classes 2 and 5
    v = fill(16'h0000);
    v[2*DATA_W +: DATA_W] = 16'h3000;
    v[5*DATA_W +: DATA_W] = 16'h3000;
    send(v, 1, 1);
    wait_drain(50, 0);

    // All zero
    send(fill(16'h0000), 1, 1);
    wait_drain(50, 0);

    // Backpressure: result A held, B waits in DONE, then both drain back to back
    res_ready = 1'b0;
    v = fill(16'h0100);
    v[3*DATA_W +: DATA_W] = 16'h6000;
    ea = model(v);
    send(v, 1, 1);
    v = fill(16'h0200);
    v[8*DATA_W +: DATA_W] = 16'h5000;
    v[1*DATA_W +: DATA_W] = 16'h4800;
    eb = model(v);
    send(v, 30, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("bp_hold_valid", 32'(res_valid_a), 1);
    chk("bp_hold_class", 32'(class_idx_a), 32'(ea.idx));
    chk("bp_hold_top1",  32'(top1_val_a), 32'(ea.val));
    chk("bp_busy",       32'(busy_a), 1);
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_swap_valid", 32'(res_valid_a), 1);
    chk("bp_swap_class", 32'(class_idx_a), 32'(eb.idx));
    wait_drain(50, 0);
    chk_drops("bp");

    // Overrun strobes at T+3 and T+11
    send(rand_frame(), 1, 1);
    send(rand_frame(), 3, 0);
    send(rand_frame(), 8, 0);
    exp_drops += 2;
    wait_drain(50, 0);
    chk_drops("overrun");

    // Reset mid-scan discards the frame
    send(rand_frame(), 1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;
    chk("midrst_res_valid", 32'(res_valid_a), 0);
    chk("midrst_busy",      32'(busy_a), 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_result", 32'(res_valid_a), 0);
    send(rand_frame(), 1, 1);
    wait_drain(50, 0);

    // Saturation: five strobes while scanning
    send(rand_frame(), 1, 1);
    repeat (5) send(rand_frame(), 1, 0);
    exp_drops += 5;
    wait_drain(50, 0);
    chk_drops("sat");

    // Randomized frames with random consumer stalls
    for (int f = 0; f < 40; f++) begin
      send(rand_frame(), $urandom_range(1, 4), 1);
      wait_drain(400, 1);
      res_ready = 1'b1;
    end
    chk_drops("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
